// File: rtl/disp_scan_pkg.sv
// Shared constants for the 7-segment scanner: active-low hex glyph table
// and all-off patterns for segments and anodes.
package disp_scan_pkg;

  localparam int unsigned MAX_DIGITS = 16;

  typedef logic [6:0] seg_t;

  localparam seg_t                  SEG_OFF = 7'h7F;
  localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

  // Index 15 first; seg[0]..seg[6] = a..g, 0 = segment lit.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/disp_scan_hex7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex7seg
  import disp_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_SEG[nib_i];
  end

endmodule

// File: rtl/disp_scan.sv
// 12-digit multiplexed hex display scanner with frame-coherent snapshot.
// Optional leading-zero suppression when DISP_ZERO_BLANK_EN is defined.
module disp_scan
  import disp_scan_pkg::*;
#(
  parameter int unsigned DIGITS = 12,
  parameter int unsigned DIV    = 50000,
  parameter int unsigned BLANK  = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   d,
  input  logic                  hold,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic                load_q, load_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q;

  logic       tick, last_digit, blank_win, digit_blank;
  logic [3:0] nib;
  logic [6:0] seg_dec;

  assign tick       = (cnt_q == CW'(DIV - 1));
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign blank_win  = (cnt_q < CW'(BLANK));
  assign nib        = snap_q[4*idx_q +: 4];

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (seg_dec)
  );

`ifdef DISP_ZERO_BLANK_EN
  logic zero_above;

  // Blank the current digit when it and every more-significant nibble is zero.
  always_comb begin
    zero_above = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i >= 32'(idx_q) && snap_q[4*i +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
    end
    digit_blank = (idx_q != '0) && zero_above;
  end
`else
  assign digit_blank = 1'b0;
`endif

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
    // hold is only looked at on the frame boundary, so a frame never mixes values.
    load_d = tick && last_digit && !hold;
    snap_d = load_d ? d : snap_q;
    an_d   = blank_win ? AN_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx_q);
    seg_d  = (blank_win || digit_blank) ? SEG_OFF : seg_dec;
  end

  // frame is delayed one more stage so it lines up with digit 0's first output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      load_q  <= 1'b0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF[DIGITS-1:0];
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      load_q  <= load_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= load_q;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_q;

endmodule
